// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage of the 5-stage in-order core.
// Accepts instructions from EXE and waits for the data-SRAM load response.
// Aligns and extends load data, then hands {gr_we,dest,final_result,pc} to WB.
// A one-entry response buffer holds a load response that lands while WB is stalled.
// Optional feature macro: MEM_FWD_EN drives the MEM->ID forwarding bus
// (ms_to_ds_bus); when it is undefined that bus is tied to zero.
module mem_stage #(
  localparam int unsigned ES_TO_MS_BUS_WD = 78,
  localparam int unsigned MS_TO_WS_BUS_WD = 70,
  localparam int unsigned MS_TO_DS_BUS_WD = 39
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  input  logic                       ws_allowin,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  input  logic                       data_sram_data_ok,
  input  logic [31:0]                data_sram_rdata,
  output logic [MS_TO_DS_BUS_WD-1:0] ms_to_ds_bus
);

  // EXE->MEM payload; ld_op one-hot order is {ld.w, ld.hu, ld.h, ld.bu, ld.b}
  typedef struct packed {
    logic [4:0]  ld_op;
    logic        mem_req;
    logic [1:0]  addr_lo;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;
  } es_bus_t;

  logic        ms_valid;
  es_bus_t     ms_r;
  logic        data_ok_seen;
  logic [31:0] rdata_buf;
  logic        ms_ready_go;
  logic        ms_leave;
  logic [31:0] ld_word;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_value;
  logic [31:0] final_result;

  // Stage valid bit: refilled from EXE whenever MEM can accept
  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid <= 1'b0;
    end else if (ms_allowin) begin
      ms_valid <= es_to_ms_valid;
    end
  end

  // Pipeline payload register
  always_ff @(posedge clk) begin
    if (reset) begin
      ms_r <= '0;
    end else if (es_to_ms_valid && ms_allowin) begin
      ms_r <= es_bus_t'(es_to_ms_bus);
    end
  end

  // Response buffer: first data_ok for the resident load is kept until the instruction leaves
  always_ff @(posedge clk) begin
    if (reset) begin
      data_ok_seen <= 1'b0;
      rdata_buf    <= 32'h0;
    end else if (ms_leave) begin
      data_ok_seen <= 1'b0;
      rdata_buf    <= 32'h0;
    end else if (data_sram_data_ok && ms_valid && ms_r.mem_req && !data_ok_seen) begin
      data_ok_seen <= 1'b1;
      rdata_buf    <= data_sram_rdata;
    end
  end

  // Handshake; a same-cycle response lets the load retire without a bubble
  always_comb begin
    ms_ready_go    = !ms_r.mem_req || data_ok_seen || data_sram_data_ok;
    ms_to_ws_valid = ms_valid && ms_ready_go;
    ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
    ms_leave       = ms_to_ws_valid && ws_allowin;
  end

  // Load alignment and extension; half-word selection ignores addr_lo[0]
  always_comb begin
    ld_word = data_ok_seen ? rdata_buf : data_sram_rdata;
    unique case (ms_r.addr_lo)
      2'd0:    ld_byte = ld_word[7:0];
      2'd1:    ld_byte = ld_word[15:8];
      2'd2:    ld_byte = ld_word[23:16];
      default: ld_byte = ld_word[31:24];
    endcase
    ld_half = ms_r.addr_lo[1] ? ld_word[31:16] : ld_word[15:0];
    if (ms_r.ld_op[0]) begin
      ld_value = {{24{ld_byte[7]}}, ld_byte};
    end else if (ms_r.ld_op[1]) begin
      ld_value = {24'h0, ld_byte};
    end else if (ms_r.ld_op[2]) begin
      ld_value = {{16{ld_half[15]}}, ld_half};
    end else if (ms_r.ld_op[3]) begin
      ld_value = {16'h0, ld_half};
    end else begin
      ld_value = ld_word;
    end
    final_result = (ms_r.mem_req && (|ms_r.ld_op)) ? ld_value : ms_r.alu_result;
  end

  // MEM->WB payload
  always_comb begin
    ms_to_ws_bus = {ms_r.gr_we, ms_r.dest, final_result, ms_r.pc};
  end

`ifdef MEM_FWD_EN
  // Forwarding to ID; load_pending tells ID to stall rather than forward
  always_comb begin
    ms_to_ds_bus = {ms_valid && ms_r.gr_we && (ms_r.dest != 5'd0),
                    ms_valid && ms_r.mem_req && !ms_ready_go,
                    ms_r.dest,
                    final_result};
  end
`else
  // Forwarding disabled: bus held at zero
  always_comb begin
    ms_to_ds_bus = '0;
  end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: table-driven vectors plus hand sequences for mem_stage, with a
// scoreboard queue of expected WB payloads popped on each MEM->WB handshake.
module tb_mem_stage;

  logic        clk;
  logic        reset;
  logic        ms_allowin;
  logic        es_to_ms_valid;
  logic [77:0] es_to_ms_bus;
  logic        ws_allowin;
  logic        ms_to_ws_valid;
  logic [69:0] ms_to_ws_bus;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic [38:0] ms_to_ds_bus;

  mem_stage dut (
    .clk               (clk),
    .reset             (reset),
    .ms_allowin        (ms_allowin),
    .es_to_ms_valid    (es_to_ms_valid),
    .es_to_ms_bus      (es_to_ms_bus),
    .ws_allowin        (ws_allowin),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .ms_to_ds_bus      (ms_to_ds_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  ld_op;
    logic        mem_req;
    logic [1:0]  lo;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu;
    logic [31:0] rdata;
    int          delay;
    logic [31:0] exp;
  } vec_t;

  localparam logic [4:0] LD_B  = 5'b00001;
  localparam logic [4:0] LD_BU = 5'b00010;
  localparam logic [4:0] LD_H  = 5'b00100;
  localparam logic [4:0] LD_HU = 5'b01000;
  localparam logic [4:0] LD_W  = 5'b10000;

  vec_t        vt[11];
  logic [69:0] sb[$];
  logic [69:0] exp_bus;
  int          n_cmp;
  int          n_bad;

  task automatic chk(input string name, input logic [69:0] act, input logic [69:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Scoreboard: push on EXE->MEM acceptance, pop/compare on MEM->WB acceptance
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (ms_to_ws_valid && ws_allowin) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_empty: got bus %h expected none queued", ms_to_ws_bus);
        end else begin
          chk("wb_bus", ms_to_ws_bus, sb.pop_front());
        end
      end
      if (es_to_ms_valid && ms_allowin) sb.push_back(exp_bus);
    end
  end

  task automatic set_instr(input logic [4:0] ld_op, input logic mem_req, input logic [1:0] lo,
                           input logic gr_we, input logic [4:0] dest, input logic [31:0] alu,
                           input logic [31:0] pc, input logic [31:0] expr);
    es_to_ms_bus = {ld_op, mem_req, lo, gr_we, dest, alu, pc};
    exp_bus      = {gr_we, dest, expr, pc};
  endtask

  // Present one instruction and return at the start of its MEM cycle
  task automatic send(input logic [4:0] ld_op, input logic mem_req, input logic [1:0] lo,
                      input logic gr_we, input logic [4:0] dest, input logic [31:0] alu,
                      input logic [31:0] pc, input logic [31:0] expr);
    int n;
    set_instr(ld_op, mem_req, lo, gr_we, dest, alu, pc, expr);
    es_to_ms_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ms_allowin && n < 50);
    if (!ms_allowin) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: ms_allowin got %b expected 1", ms_allowin);
    end
    @(posedge clk); #1;
    es_to_ms_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time got %0t expected completion", $time);
    $fatal(1);
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    vt[0]  = '{5'b0,  1'b0, 2'd0, 1'b1, 5'd5,  32'h1234_5678, 32'h0,          0, 32'h1234_5678};
    vt[1]  = '{LD_B,  1'b1, 2'd3, 1'b1, 5'd6,  32'h0000_0103, 32'h80AA_BBCC, 0, 32'hFFFF_FF80};
    vt[2]  = '{LD_HU, 1'b1, 2'd2, 1'b1, 5'd8,  32'h0000_0202, 32'hBEEF_0001, 3, 32'h0000_BEEF};
    vt[3]  = '{LD_BU, 1'b1, 2'd1, 1'b1, 5'd9,  32'h0000_0301, 32'h1234_5678, 1, 32'h0000_0056};
    vt[4]  = '{LD_H,  1'b1, 2'd0, 1'b1, 5'd10, 32'h0000_0400, 32'h1234_F00D, 0, 32'hFFFF_F00D};
    vt[5]  = '{LD_H,  1'b1, 2'd1, 1'b1, 5'd11, 32'h0000_0501, 32'h8001_7FFF, 0, 32'h0000_7FFF};
    vt[6]  = '{LD_W,  1'b1, 2'd0, 1'b1, 5'd12, 32'h0000_0600, 32'hCAFE_BABE, 2, 32'hCAFE_BABE};
    vt[7]  = '{5'b0,  1'b0, 2'd0, 1'b0, 5'd0,  32'h0000_1000, 32'h0,          0, 32'h0000_1000};
    vt[8]  = '{LD_B,  1'b1, 2'd0, 1'b1, 5'd13, 32'h0000_0800, 32'h0000_007F, 0, 32'h0000_007F};
    vt[9]  = '{LD_BU, 1'b1, 2'd2, 1'b1, 5'd14, 32'h0000_0902, 32'h00FF_0000, 1, 32'h0000_00FF};
    vt[10] = '{LD_HU, 1'b1, 2'd3, 1'b1, 5'd15, 32'h0000_0A03, 32'hA5A5_1111, 0, 32'h0000_A5A5};

    reset = 1'b1;
    es_to_ms_valid = 1'b0;
    es_to_ms_bus = '0;
    exp_bus = '0;
    ws_allowin = 1'b1;
    data_sram_data_ok = 1'b0;
    data_sram_rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_valid",   70'(ms_to_ws_valid), 70'(1'b0));
    chk("rst_allowin", 70'(ms_allowin),     70'(1'b1));
    chk("rst_ws_bus",  ms_to_ws_bus,        70'(0));
    chk("rst_ds_bus",  70'(ms_to_ds_bus),   70'(0));
    @(posedge clk); #1;
    reset = 1'b0;

    // Table-driven single instructions with WB always ready
    for (int i = 0; i < 11; i++) begin
      send(vt[i].ld_op, vt[i].mem_req, vt[i].lo, vt[i].gr_we, vt[i].dest, vt[i].alu,
           32'h1C00_0000 + 32'(i * 4), vt[i].exp);
      if (vt[i].mem_req) begin
        for (int d = 0; d < vt[i].delay; d++) begin
          @(negedge clk);
          chk("stall_allowin", 70'(ms_allowin),     70'(1'b0));
          chk("stall_valid",   70'(ms_to_ws_valid), 70'(1'b0));
          @(posedge clk); #1;
          data_sram_rdata = $urandom;
        end
        data_sram_data_ok = 1'b1;
        data_sram_rdata = vt[i].rdata;
      end
      @(negedge clk);
      chk("retire_valid", 70'(ms_to_ws_valid), 70'(1'b1));
      @(posedge clk); #1;
      data_sram_data_ok = 1'b0;
      data_sram_rdata = $urandom;
    end

    // Response captured while WB stalls, then the SRAM output changes
    ws_allowin = 1'b0;
    send(LD_W, 1'b1, 2'd0, 1'b1, 5'd4, 32'h0, 32'h1C00_0100, 32'hDEAD_BEEF);
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    data_sram_data_ok = 1'b0;
    data_sram_rdata = 32'h0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("hold_valid",   70'(ms_to_ws_valid),       70'(1'b1));
      chk("hold_allowin", 70'(ms_allowin),           70'(1'b0));
      chk("hold_data",    70'(ms_to_ws_bus[63:32]),  70'(32'hDEAD_BEEF));
      @(posedge clk); #1;
    end
    ws_allowin = 1'b1;
    @(negedge clk);
    chk("hold_release", 70'(ms_allowin), 70'(1'b1));
    @(posedge clk); #1;

    // data_ok, ws_allowin and a new instruction in the same cycle
    send(LD_W, 1'b1, 2'd0, 1'b1, 5'd16, 32'h0, 32'h1C00_0200, 32'h0BAD_F00D);
    set_instr(5'b0, 1'b0, 2'd0, 1'b1, 5'd17, 32'h5555_AAAA, 32'h1C00_0204, 32'h5555_AAAA);
    es_to_ms_valid = 1'b1;
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    chk("simul_allowin", 70'(ms_allowin), 70'(1'b1));
    @(posedge clk); #1;
    es_to_ms_valid = 1'b0;
    data_sram_data_ok = 1'b0;
    data_sram_rdata = 32'h0;
    @(negedge clk);
    chk("simul_next_valid", 70'(ms_to_ws_valid), 70'(1'b1));
    @(posedge clk); #1;
    send(LD_W, 1'b1, 2'd0, 1'b1, 5'd18, 32'h0, 32'h1C00_0208, 32'h3333_4444);
    @(negedge clk);
    chk("buf_clear_wait", 70'(ms_to_ws_valid), 70'(1'b0));
    @(posedge clk); #1;
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h3333_4444;
    @(negedge clk);
    chk("buf_clear_ret", 70'(ms_to_ws_valid), 70'(1'b1));
    @(posedge clk); #1;
    data_sram_data_ok = 1'b0;

    // Reset while a load waits; stale data_ok after release must be ignored
    send(LD_W, 1'b1, 2'd0, 1'b1, 5'd3, 32'h0, 32'h1C00_0300, 32'h9999_9999);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_rst_valid",   70'(ms_to_ws_valid), 70'(1'b0));
    chk("mid_rst_allowin", 70'(ms_allowin),     70'(1'b1));
    chk("mid_rst_bus",     ms_to_ws_bus,        70'(0));
    chk("mid_rst_ds",      70'(ms_to_ds_bus),   70'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete();
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h1111_1111;
    @(negedge clk);
    chk("stale_valid",   70'(ms_to_ws_valid), 70'(1'b0));
    chk("stale_allowin", 70'(ms_allowin),     70'(1'b1));
    @(posedge clk); #1;
    data_sram_data_ok = 1'b0;
    send(LD_W, 1'b1, 2'd0, 1'b1, 5'd9, 32'h0, 32'h1C00_0400, 32'h2222_2222);
    @(negedge clk);
    chk("post_rst_wait", 70'(ms_to_ws_valid), 70'(1'b0));
    @(posedge clk); #1;
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h2222_2222;
    @(negedge clk);
    chk("post_rst_ret", 70'(ms_to_ws_valid), 70'(1'b1));
    @(posedge clk); #1;
    data_sram_data_ok = 1'b0;

    // Forwarding bus around a pending ld.w to r7
    send(LD_W, 1'b1, 2'd0, 1'b1, 5'd7, 32'h0, 32'h1C00_0500, 32'h7654_3210);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
`ifdef MEM_FWD_EN
      chk("fwd_pending", 70'(ms_to_ds_bus[38:32]), 70'({1'b1, 1'b1, 5'd7}));
`else
      chk("ds_zero_wait", 70'(ms_to_ds_bus), 70'(0));
`endif
      @(posedge clk); #1;
    end
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h7654_3210;
    @(negedge clk);
`ifdef MEM_FWD_EN
    chk("fwd_data", 70'(ms_to_ds_bus), 70'({1'b1, 1'b0, 5'd7, 32'h7654_3210}));
`else
    chk("ds_zero_data", 70'(ms_to_ds_bus), 70'(0));
`endif
    @(posedge clk); #1;
    data_sram_data_ok = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("sb_drained", 70'(sb.size()), 70'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
